// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequences one RTC register access on a multiplexed AD bus.
// The address phase comes first, then a CS_n-high gap, then the data phase
// (write or read). One further request can wait in a single-entry buffer.
// Every output is a flop. Output values are decoded from the state being
// entered, so they line up with the state register.
//
// Handshake: a request is the first cycle after a registered rising edge of
// Acceso. Mod, Dir and Dato_in are captured on that same edge. FRW pulses for
// one cycle when a transaction or the power-up delay completes. Overrun pulses
// for one cycle when a request arrives while the buffer is already full.
module rtc_bus_ctrl #(
  parameter int T_STB  = 4,
  parameter int T_GAP  = 2,
  parameter int T_INIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Acceso,
  input  logic       Mod,
  input  logic [7:0] Dir,
  input  logic [7:0] Dato_in,
  output logic       FRW,
  output logic [7:0] Dato_out,
  output logic       Busy,
  output logic       Overrun,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_A_SET, S_A_STB, S_A_HLD,
    S_GAP, S_D_SET, S_D_STB, S_D_HLD, S_DONE
  } state_t;

  // The counter is 8 bits wide so that it can also time INIT (up to 255 cycles).
  localparam logic [7:0] STB_M1  = 8'(T_STB - 1);
  localparam logic [7:0] GAP_M1  = 8'(T_GAP - 1);
  localparam logic [7:0] INIT_M1 = 8'(T_INIT - 1);

  state_t     state, nxt;
  logic [7:0] cnt;
  logic       acc_q1, acc_q2, req;
  logic       s_mod, cur_mod, pend_mod, n_mod;
  logic [7:0] s_dir, cur_dir, pend_dir, n_dir;
  logic [7:0] s_din, cur_din, pend_din, n_din;
  logic       pend_v, start_pend, start_new;

  assign req       = acc_q1 & ~acc_q2;
  assign dbg_state = state;

  // Register Acceso twice for edge detection, and capture the request fields
  // on the same edge that captures Acceso.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q1 <= 1'b0;
      acc_q2 <= 1'b0;
      s_mod  <= 1'b0;
      s_dir  <= 8'h00;
      s_din  <= 8'h00;
    end else begin
      acc_q1 <= Acceso;
      acc_q2 <= acc_q1;
      s_mod  <= Mod;
      s_dir  <= Dir;
      s_din  <= Dato_in;
    end
  end

  // Next-state decode. A buffered request is served before a fresh one.
  always_comb begin
    nxt        = state;
    start_pend = 1'b0;
    start_new  = 1'b0;
    case (state)
      S_INIT:  if (cnt == INIT_M1) nxt = S_DONE;
      S_IDLE: begin
        if (pend_v) begin
          nxt        = S_A_SET;
          start_pend = 1'b1;
        end else if (req) begin
          nxt       = S_A_SET;
          start_new = 1'b1;
        end
      end
      S_A_SET: nxt = S_A_STB;
      S_A_STB: if (cnt == STB_M1) nxt = S_A_HLD;
      S_A_HLD: nxt = S_GAP;
      S_GAP:   if (cnt == GAP_M1) nxt = S_D_SET;
      S_D_SET: nxt = S_D_STB;
      S_D_STB: if (cnt == STB_M1) nxt = S_D_HLD;
      S_D_HLD: nxt = S_DONE;
      S_DONE: begin
        if (pend_v) begin
          nxt        = S_A_SET;
          start_pend = 1'b1;
        end else begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_INIT;
    endcase
    n_mod = start_pend ? pend_mod : (start_new ? s_mod : cur_mod);
    n_dir = start_pend ? pend_dir : (start_new ? s_dir : cur_dir);
    n_din = start_pend ? pend_din : (start_new ? s_din : cur_din);
  end

  // FSM state, phase counter, current transaction and all registered outputs.
  // Reset is asynchronous, so the strobes release immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_INIT;
      cnt      <= 8'h00;
      cur_mod  <= 1'b0;
      cur_dir  <= 8'h00;
      cur_din  <= 8'h00;
      CS_n     <= 1'b1;
      RD_n     <= 1'b1;
      WR_n     <= 1'b1;
      AD       <= 1'b1;
      bus_oe   <= 1'b0;
      bus_out  <= 8'h00;
      Dato_out <= 8'h00;
      FRW      <= 1'b0;
      Busy     <= 1'b1;
      Overrun  <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= (nxt != state) ? 8'h00 : cnt + 8'h01;
      cur_mod <= n_mod;
      cur_dir <= n_dir;
      cur_din <= n_din;
      Busy    <= (nxt != S_IDLE);
      FRW     <= (nxt == S_DONE);
      Overrun <= req && pend_v && (state != S_IDLE);
      CS_n    <= 1'b1;
      RD_n    <= 1'b1;
      WR_n    <= 1'b1;
      AD      <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= 8'h00;
      case (nxt)
        S_A_SET, S_A_STB, S_A_HLD: begin
          CS_n    <= 1'b0;
          AD      <= 1'b0;
          bus_oe  <= 1'b1;
          bus_out <= n_dir;
          if (nxt == S_A_STB) WR_n <= 1'b0;
        end
        S_D_SET, S_D_STB, S_D_HLD: begin
          CS_n    <= 1'b0;
          bus_oe  <= n_mod;
          bus_out <= n_din;
          if (nxt == S_D_STB) begin
            if (n_mod) WR_n <= 1'b0;
            else       RD_n <= 1'b0;
          end
        end
        default: ;
      endcase
      // Read data is captured on the edge that ends the last read strobe cycle.
      if (state == S_D_STB && nxt == S_D_HLD && !cur_mod) Dato_out <= bus_in;
    end
  end

  // One-deep pending buffer. It fills outside IDLE and is consumed on entry
  // to A_SET. When it is full, a new request is dropped and Overrun pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_v   <= 1'b0;
      pend_mod <= 1'b0;
      pend_dir <= 8'h00;
      pend_din <= 8'h00;
    end else if (state == S_IDLE) begin
      if (pend_v) begin
        pend_v <= req;
        if (req) begin
          pend_mod <= s_mod;
          pend_dir <= s_dir;
          pend_din <= s_din;
        end
      end
    end else if (req && !pend_v) begin
      pend_v   <= 1'b1;
      pend_mod <= s_mod;
      pend_dir <= s_dir;
      pend_din <= s_din;
    end else if (state == S_DONE && pend_v) begin
      pend_v <= 1'b0;
    end
  end

endmodule
